// File: rtl/frodo_pkg.sv
// Shared types and constants for the Frodo inner-product MAC sequencer.
// Holds the FSM state enum, MAC latency, word width and secret range.
package frodo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT1,
        WAIT2,
        OUT
    } state_t;

    localparam int MAC_LAT   = 2;
    localparam int FRODO_Q_W = 16;
    localparam int S_MIN     = -16;
    localparam int S_MAX     = 15;

    // s is legal when it sign-extends from 5 bits, i.e. lies in [S_MIN, S_MAX]
    function automatic logic s_out_of_range(input logic [7:0] s);
        return !((s[7:4] == 4'h0) || (s[7:4] == 4'hF));
    endfunction

endpackage

// File: rtl/frodo_mac_seq.sv
// Sequences ADDER_FRODO over len terms: out = e + sum a[k]*s[k] mod 2^16.
// Ports: start/len/e_data job in; rd_* buffer reads; mac_* MAC drive; out_* valid/ready result.
module frodo_mac_seq
    import frodo_pkg::*;
#(
    parameter int N_MAX = 640,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [AW-1:0]        len,
    input  logic [FRODO_Q_W-1:0] e_data,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [FRODO_Q_W-1:0] a_data,
    input  logic [7:0]           s_data,
    output logic                 mac_en,
    output logic [FRODO_Q_W-1:0] mac_a,
    output logic [7:0]           mac_b,
    output logic [FRODO_Q_W-1:0] mac_c,
    input  logic [FRODO_Q_W-1:0] mac_result,
    output logic                 busy,
    output logic                 out_valid,
    output logic [FRODO_Q_W-1:0] out_data,
    input  logic                 out_ready,
    output logic                 range_err
);

    localparam logic [AW-1:0] LEN_MAX = AW'(N_MAX);

    state_t               state;
    logic [AW-1:0]        k;
    logic [AW-1:0]        len_q;
    logic [FRODO_Q_W-1:0] acc;

    // The accumulator only moves at the end of WAIT2, so it stays
    // constant across the MAC's second (add) cycle.
    assign rd_addr  = k;
    assign mac_c    = acc;
    assign out_data = acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            k         <= '0;
            len_q     <= '0;
            acc       <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            rd_en     <= 1'b0;
            mac_en    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            range_err <= 1'b0;
        end else begin
            rd_en  <= 1'b0;
            mac_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= e_data;
                        k         <= '0;
                        range_err <= 1'b0;
                        busy      <= 1'b1;
                        len_q     <= (len > LEN_MAX) ? LEN_MAX : len;
                        if (len == '0) begin
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            rd_en <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    mac_a     <= a_data;
                    mac_b     <= s_data;
                    range_err <= range_err | s_out_of_range(s_data);
                    mac_en    <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: state <= WAIT1;
                WAIT1: state <= WAIT2;
                // mac_result is final here: two edges after the launch edge
                WAIT2: begin
                    acc <= mac_result;
                    if (k == len_q - 1'b1) begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        k     <= k + 1'b1;
                        rd_en <= 1'b1;
                        state <= FETCH;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frodo_mac_seq.sv
// Self-checking bench for frodo_mac_seq with a two-stage MAC and two ROMs.
// Expected sums come from plain integer arithmetic over the ROM contents.
module tb_frodo_mac_seq;

    localparam int N_MAX = 640;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic [15:0]   e_data = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   a_data;
    logic [7:0]    s_data;
    logic          mac_en;
    logic [15:0]   mac_a;
    logic [7:0]    mac_b;
    logic [15:0]   mac_c;
    logic [15:0]   mac_result;
    logic          busy;
    logic          out_valid;
    logic [15:0]   out_data;
    logic          out_ready = 1'b0;
    logic          range_err;

    int vectors = 0;
    int miscompares = 0;
    int n_rd = 0;
    int n_mac = 0;

    logic [15:0] a_mem [1024];
    logic [7:0]  s_mem [1024];

    always #5 clk = ~clk;

    frodo_mac_seq #(.N_MAX(N_MAX), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .e_data(e_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_data(a_data), .s_data(s_data),
        .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_result(mac_result), .busy(busy), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .range_err(range_err)
    );

    // 1-cycle-latency buffers
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[rd_addr];
            s_data <= s_mem[rd_addr];
        end
    end

    // ADDER_FRODO stand-in: multiply on the launch edge, add in_c one edge later
    logic [15:0] prod;
    logic        en_d;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod       <= '0;
            en_d       <= 1'b0;
            mac_result <= '0;
        end else begin
            en_d <= mac_en;
            if (mac_en) prod <= mac_a * {{8{mac_b[7]}}, mac_b};
            if (en_d) mac_result <= prod + mac_c;
        end
    end

    always @(negedge clk) begin
        if (rd_en) n_rd++;
        if (mac_en) n_mac++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int n);
        return (n > N_MAX) ? N_MAX : n;
    endfunction

    function automatic logic [15:0] ref_sum(input int n, input logic [15:0] e);
        int s;
        s = int'(e);
        for (int i = 0; i < clamp(n); i++)
            s += int'(a_mem[i]) * int'($signed(s_mem[i]));
        return 16'(s);
    endfunction

    function automatic logic ref_err(input int n);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < clamp(n); i++)
            if (int'($signed(s_mem[i])) < -16 || int'($signed(s_mem[i])) > 15) bad = 1'b1;
        return bad;
    endfunction

    task automatic fill_rom(input bit allow_bad);
        for (int i = 0; i < 1024; i++) begin
            a_mem[i] = 16'($urandom);
            if (allow_bad && $urandom_range(0, 7) == 0) s_mem[i] = 8'($urandom);
            else s_mem[i] = 8'($urandom_range(0, 31) - 16);
        end
    endtask

    // Called just after the edge that accepted start.
    task automatic wait_out(input string tag, input int n, input logic [15:0] e,
                            input int rd0, input int mac0, input bit do_hs);
        int cnt;
        int nn;
        nn = clamp(n);
        cnt = 0;
        while (!out_valid && cnt < 5 * nn + 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_lat"}, cnt, (nn == 0) ? 0 : 5 * nn);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, ref_sum(n, e));
        chk({tag, "_rerr"}, range_err, ref_err(n));
        chk({tag, "_nrd"}, n_rd - rd0, nn);
        chk({tag, "_nmac"}, n_mac - mac0, nn);
        if (do_hs) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({tag, "_hs_valid"}, out_valid, 0);
            chk({tag, "_hs_busy"}, busy, 0);
        end
    endtask

    task automatic launch(input int n, input logic [15:0] e);
        @(negedge clk);
        start  = 1'b1;
        len    = AW'(n);
        e_data = e;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_job(input string tag, input int n, input logic [15:0] e, input bit do_hs);
        int rd0;
        int mac0;
        rd0 = n_rd;
        mac0 = n_mac;
        launch(n, e);
        chk({tag, "_busy"}, busy, 1);
        wait_out(tag, n, e, rd0, mac0, do_hs);
    endtask

    initial begin
        int rd0;
        int mac0;
        logic [15:0] e;
        int n;

        fill_rom(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rerr", range_err, 0);
        @(negedge clk);
        rstn = 1'b1;

        a_mem[0] = 16'h0003; s_mem[0] = 8'd2;
        run_job("t1", 1, 16'h0005, 1);
        chk("t1_value", ref_sum(1, 16'h0005), 16'h000B);

        for (int i = 0; i < 4; i++) begin
            a_mem[i] = 16'(i + 1);
            s_mem[i] = 8'hFF;
        end
        run_job("t2", 4, 16'h0000, 1);

        run_job("t3", 0, 16'h1234, 1);

        a_mem[0] = 16'hFFFF; s_mem[0] = 8'h0F;
        a_mem[1] = 16'h8000; s_mem[1] = 8'hF0;
        run_job("t4", 2, 16'hFFFF, 1);
        s_mem[0] = 8'h20;
        run_job("t4b", 1, 16'h0000, 1);

        // idle out_ready must do nothing
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_ready_busy", busy, 0);
        chk("idle_ready_valid", out_valid, 0);

        // backpressure with ignored start pulses
        fill_rom(0);
        e = 16'($urandom);
        run_job("bp", 3, e, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = i[0];
            len = AW'(1);
            @(posedge clk);
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, ref_sum(3, e));
            chk("bp_busy", busy, 1);
        end
        // start during the handshake edge is deferred by one cycle
        @(negedge clk);
        e = 16'($urandom);
        start = 1'b1;
        len = AW'(2);
        e_data = e;
        out_ready = 1'b1;
        rd0 = n_rd;
        mac0 = n_mac;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_start_busy", busy, 0);
        chk("hs_start_valid", out_valid, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hs_start_accept", busy, 1);
        wait_out("hs_job", 2, e, rd0, mac0, 1);

        // abort in WAIT1 of term 3
        fill_rom(0);
        launch(8, 16'($urandom));
        repeat (13) @(posedge clk);
        #2;
        mac0 = n_mac;
        rstn = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mac_en", mac_en, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_data", out_data, 0);
        chk("abort_mac_a", mac_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_mac", n_mac - mac0, 0);
        chk("abort_no_out", out_valid, 0);
        run_job("post_abort", 1, 16'($urandom), 1);

        // random jobs
        for (int j = 0; j < 6; j++) begin
            fill_rom(1);
            n = $urandom_range(1, 12);
            run_job("rnd", n, 16'($urandom), 1);
        end
        run_job("rnd_zero", 0, 16'($urandom), 1);
        fill_rom(1);
        run_job("clamp", $urandom_range(N_MAX + 1, 1023), 16'($urandom), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
